// File: rtl/axi_interconnect_crossbar_credit_arbit_if.sv
// Handshake bundle for axi_interconnect_crossbar_credit_arbit.
//   s_addr_info  : per-port address info, port i at slice i
//   s_addr_valid : per-port request
//   s_addr_ready : one-hot grant back to the requesting ports
//   addr_info    : {info, granted index}, index in the LSBs
//   addr_valid   : downstream valid
//   addr_ready   : downstream ready
//   rsp_done     : per-port transaction-complete pulse
// Modport "slave" is the crossbar's own view; "master" is the view of the
// environment that drives requests, completions and downstream ready.
interface axi_interconnect_crossbar_credit_arbit_if #(
  parameter int NUM_SLAVE      = 4,
  parameter int WIDTH_ADDRINFO = 64,
  parameter int WIDTH_SALVE    = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1
);
  logic [NUM_SLAVE*WIDTH_ADDRINFO-1:0]  s_addr_info;
  logic [NUM_SLAVE-1:0]                 s_addr_valid;
  logic [NUM_SLAVE-1:0]                 s_addr_ready;
  logic [WIDTH_ADDRINFO+WIDTH_SALVE-1:0] addr_info;
  logic                                 addr_valid;
  logic                                 addr_ready;
  logic [NUM_SLAVE-1:0]                 rsp_done;

  modport slave (
    input  s_addr_info, s_addr_valid, addr_ready, rsp_done,
    output s_addr_ready, addr_info, addr_valid
  );

  modport master (
    output s_addr_info, s_addr_valid, addr_ready, rsp_done,
    input  s_addr_ready, addr_info, addr_valid
  );
endinterface

// File: rtl/axi_interconnect_crossbar_credit_arbit.sv
// Credit-limited round-robin address arbiter.
// Selects one of NUM_SLAVE requesting ports per load cycle, forwards its
// address info (tagged with the port index) through a single output register,
// and tracks per-port outstanding transactions so a port at its limit is
// skipped until a rsp_done pulse returns a credit.
//
// Ports:
//   clk_sys        : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   bus            : handshake bundle (slave modport), see the interface file
//   busy           : any credit counter non-zero
//   err_underflow  : sticky, rsp_done seen for a port with no outstanding work
//   stat_grant_cnt : per-port 32-bit wrapping grant counters, only present
//                    when AXI_IC_CREDIT_ARBIT_STAT_EN is defined
//
// Optional feature macro: AXI_IC_CREDIT_ARBIT_STAT_EN
module axi_interconnect_crossbar_credit_arbit #(
  parameter int NUM_SLAVE       = 4,
  parameter int WIDTH_ADDRINFO  = 64,
  parameter int NUM_OUTSTANDING = 4,
  parameter int WIDTH_SALVE     = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1,
  parameter int WIDTH_CNT       = $clog2(NUM_OUTSTANDING + 1),
  parameter int U_DLY           = 1
) (
  input  logic clk_sys,
  input  logic rst_n,
  axi_interconnect_crossbar_credit_arbit_if.slave bus,
  output logic busy,
  output logic err_underflow
`ifdef AXI_IC_CREDIT_ARBIT_STAT_EN
  ,
  output logic [32*NUM_SLAVE-1:0] stat_grant_cnt
`endif
);

  // Elaboration-time parameter sanity checks.
  if (NUM_SLAVE < 1 || NUM_SLAVE > 4) begin : g_bad_num_slave
    $error("NUM_SLAVE must be within 1..4");
  end
  if (NUM_OUTSTANDING < 1 || NUM_OUTSTANDING > 16) begin : g_bad_outstanding
    $error("NUM_OUTSTANDING must be within 1..16");
  end
  if (U_DLY < 0) begin : g_bad_dly
    $error("U_DLY must be non-negative");
  end

  typedef logic [WIDTH_SALVE-1:0] idx_t;
  typedef logic [WIDTH_CNT-1:0]   cnt_t;

  localparam int unsigned NUM_SLAVE_U = NUM_SLAVE;
  localparam cnt_t        CNT_MAX     = cnt_t'(NUM_OUTSTANDING);
  localparam idx_t        LAST_RST    = idx_t'(NUM_SLAVE - 1);

  cnt_t                              cnt [NUM_SLAVE];
  logic [NUM_SLAVE-1:0]              eligible;
  logic [NUM_SLAVE-1:0]              grant;
  idx_t                              last;
  idx_t                              winner;
  logic                              any_eligible;
  logic                              load;
  logic [WIDTH_ADDRINFO-1:0]         info_sel;
  logic                              addr_valid_q;
  logic [WIDTH_ADDRINFO+WIDTH_SALVE-1:0] addr_info_q;

  // Output register accepts a new word when empty or being drained.
  assign load = ~addr_valid_q | bus.addr_ready;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_SLAVE_U; i++) begin
      eligible[i] = bus.s_addr_valid[i] & (cnt[i] < CNT_MAX);
    end
  end

  // Round-robin search starting one past the last winner, wrapping.
  always_comb begin
    int unsigned p;
    p            = 0;
    winner       = last;
    any_eligible = 1'b0;
    for (int unsigned k = 1; k <= NUM_SLAVE_U; k++) begin
      p = (32'(last) + k) % NUM_SLAVE_U;
      if (!any_eligible && eligible[idx_t'(p)]) begin
        any_eligible = 1'b1;
        winner       = idx_t'(p);
      end
    end
  end

  // Grant is gated by rst_n so the ready outputs drop with reset, not
  // just at the next edge.
  always_comb begin
    grant = '0;
    if (rst_n && load && any_eligible) begin
      grant[winner] = 1'b1;
    end
  end

  always_comb begin
    info_sel = '0;
    for (int unsigned i = 0; i < NUM_SLAVE_U; i++) begin
      if (idx_t'(i) == winner) begin
        info_sel = bus.s_addr_info[i*WIDTH_ADDRINFO +: WIDTH_ADDRINFO];
      end
    end
  end

  assign bus.s_addr_ready = grant;
  assign bus.addr_valid   = addr_valid_q;
  assign bus.addr_info    = addr_info_q;

  // Output register and round-robin pointer. addr_info holds its last
  // value when a load cycle finds nobody eligible.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      addr_valid_q <= 1'b0;
      addr_info_q  <= '0;
      last         <= LAST_RST;
    end else if (load) begin
      addr_valid_q <= any_eligible;
      if (any_eligible) begin
        addr_info_q <= {info_sel, winner};
        last        <= winner;
      end
    end
  end

  // Credit counters. A grant and a completion in the same cycle cancel;
  // a completion alone on an empty counter flags underflow instead.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLAVE_U; i++) begin
        cnt[i] <= '0;
      end
      err_underflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLAVE_U; i++) begin
        if (grant[i] && !bus.rsp_done[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (!grant[i] && bus.rsp_done[i]) begin
          if (cnt[i] == '0) begin
            err_underflow <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVE_U; i++) begin
      if (cnt[i] != '0) begin
        busy = 1'b1;
      end
    end
  end

`ifdef AXI_IC_CREDIT_ARBIT_STAT_EN
  logic [31:0] stat_q [NUM_SLAVE];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLAVE_U; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SLAVE_U; i++) begin
        if (grant[i]) begin
          stat_q[i] <= stat_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_SLAVE_U; i++) begin
      stat_grant_cnt[i*32 +: 32] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_axi_interconnect_crossbar_credit_arbit.sv
// Self-checking bench for axi_interconnect_crossbar_credit_arbit with
// NUM_SLAVE=3, NUM_OUTSTANDING=2. A behavioural model (credit array, last
// winner, output word) predicts every output each cycle; directed scenarios
// are followed by a randomized phase and a mid-transfer reset.
module tb_axi_interconnect_crossbar_credit_arbit;
  localparam int NS = 3;
  localparam int W  = 16;
  localparam int NO = 2;
  localparam int WS = 2;
  localparam int IW = NS * W;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  logic busy;
  logic err_underflow;
`ifdef AXI_IC_CREDIT_ARBIT_STAT_EN
  logic [32*NS-1:0] stat_grant_cnt;
`endif

  axi_interconnect_crossbar_credit_arbit_if #(
    .NUM_SLAVE(NS), .WIDTH_ADDRINFO(W), .WIDTH_SALVE(WS)
  ) bus ();

  axi_interconnect_crossbar_credit_arbit #(
    .NUM_SLAVE(NS), .WIDTH_ADDRINFO(W), .NUM_OUTSTANDING(NO), .WIDTH_SALVE(WS)
  ) u_dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .bus           (bus),
    .busy          (busy),
    .err_underflow (err_underflow)
`ifdef AXI_IC_CREDIT_ARBIT_STAT_EN
    ,
    .stat_grant_cnt(stat_grant_cnt)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int              m_cnt  [NS];
  int unsigned     m_stat [NS];
  int              m_last;
  bit              m_valid;
  logic [W+WS-1:0] m_info;
  bit              m_err;
  int              grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_cnt[i]  = 0;
      m_stat[i] = 0;
    end
    m_last  = NS - 1;
    m_valid = 1'b0;
    m_info  = '0;
    m_err   = 1'b0;
  endtask

  // First eligible port after the last winner, or -1.
  function automatic int model_winner();
    for (int off = 1; off <= NS; off++) begin
      int p;
      p = (m_last + off) % NS;
      if (bus.s_addr_valid[p] && m_cnt[p] < NO) return p;
    end
    return -1;
  endfunction

  task automatic new_info();
    bus.s_addr_info = IW'({$urandom(), $urandom()});
  endtask

  // One clock: check outputs at the falling edge, then advance the model
  // across the rising edge and return 1 time unit later.
  task automatic cycle();
    bit             ld;
    int             w;
    logic [NS-1:0]  exp_rdy;
    bit             exp_busy;
    @(negedge clk_sys);
    ld       = !m_valid || bus.addr_ready;
    w        = model_winner();
    exp_rdy  = '0;
    if (ld && w >= 0) exp_rdy[w] = 1'b1;
    exp_busy = 1'b0;
    for (int i = 0; i < NS; i++) if (m_cnt[i] != 0) exp_busy = 1'b1;
    chk("s_addr_ready", 64'(bus.s_addr_ready), 64'(exp_rdy));
    chk("addr_valid", 64'(bus.addr_valid), 64'(m_valid));
    chk("addr_info", 64'(bus.addr_info), 64'(m_info));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("err_underflow", 64'(err_underflow), 64'(m_err));
`ifdef AXI_IC_CREDIT_ARBIT_STAT_EN
    for (int i = 0; i < NS; i++)
      chk("stat_grant_cnt", 64'(stat_grant_cnt[i*32 +: 32]), 64'(m_stat[i]));
`endif
    for (int i = 0; i < NS; i++) if (bus.s_addr_ready[i]) grant_log.push_back(i);
    @(posedge clk_sys);
    if (ld) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_info  = {bus.s_addr_info[w*W +: W], WS'(w)};
        m_last  = w;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < NS; i++) begin
      bit g, d;
      g = ld && (w == i);
      d = bus.rsp_done[i];
      if (g) m_stat[i]++;
      if (g && !d) m_cnt[i]++;
      else if (!g && d) begin
        if (m_cnt[i] == 0) m_err = 1'b1;
        else m_cnt[i]--;
      end
    end
    #1;
  endtask

  task automatic drain();
    bus.s_addr_valid = '0;
    bus.addr_ready   = 1'b1;
    for (int k = 0; k < NO + 1; k++) begin
      for (int i = 0; i < NS; i++) bus.rsp_done[i] = (m_cnt[i] > 0);
      cycle();
    end
    bus.rsp_done = '0;
    cycle();
  endtask

  task automatic check_reset_outputs();
    chk("rst_addr_valid", 64'(bus.addr_valid), 64'd0);
    chk("rst_addr_info", 64'(bus.addr_info), 64'd0);
    chk("rst_s_addr_ready", 64'(bus.s_addr_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_underflow", 64'(err_underflow), 64'd0);
`ifdef AXI_IC_CREDIT_ARBIT_STAT_EN
    chk("rst_stat_grant_cnt", 64'(|stat_grant_cnt), 64'd0);
`endif
  endtask

  initial begin
    int exp_order[6];
    logic [W+WS-1:0] held;
    exp_order = '{0, 1, 2, 0, 1, 2};

    // Reset with requests already pending: nothing may be granted.
    bus.s_addr_info  = '0;
    bus.s_addr_valid = 3'b111;
    bus.addr_ready   = 1'b1;
    bus.rsp_done     = '0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // All ports requesting: strict rotation 0,1,2,0,1,2 then all at limit.
    grant_log.delete();
    for (int c = 0; c < 7; c++) begin
      new_info();
      cycle();
    end
    chk("rr_grant_count", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("rr_grant_order", 64'(grant_log[i]), 64'(exp_order[i]));
    drain();

    // Port 1 alone: two grants, stall at limit, one credit returns one grant.
    grant_log.delete();
    bus.s_addr_valid = 3'b010;
    for (int c = 0; c < 5; c++) begin new_info(); cycle(); end
    chk("p1_limit_grants", 64'(grant_log.size()), 64'd2);
    chk("p1_busy", 64'(busy), 64'd1);
    bus.rsp_done = 3'b010;
    cycle();
    bus.rsp_done = '0;
    cycle();
    cycle();
    chk("p1_regrant", 64'(grant_log.size()), 64'd3);
    drain();

    // Port 0 at limit, ports 0 and 1 requesting: only port 1 is served.
    bus.s_addr_valid = 3'b001;
    for (int c = 0; c < 3; c++) begin new_info(); cycle(); end
    grant_log.delete();
    bus.s_addr_valid = 3'b011;
    for (int c = 0; c < 4; c++) begin new_info(); cycle(); end
    chk("skip_grants", 64'(grant_log.size()), 64'd2);
    foreach (grant_log[i]) chk("skip_port", 64'(grant_log[i]), 64'd1);
    drain();

    // Downstream backpressure: output holds, no grants; release grants at once.
    bus.s_addr_valid = 3'b100;
    new_info();
    cycle();
    held = bus.addr_info;
    bus.s_addr_valid = 3'b101;
    bus.addr_ready   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      new_info();
      cycle();
      chk("stall_info_stable", 64'(bus.addr_info), 64'(held));
    end
    grant_log.delete();
    bus.addr_ready = 1'b1;
    cycle();
    chk("release_grant", 64'(grant_log.size()), 64'd1);
    drain();

    // Underflow on port 2 is sticky; grant+done on port 0 cancel.
    bus.rsp_done = 3'b100;
    cycle();
    bus.rsp_done = '0;
    cycle();
    chk("underflow_sticky", 64'(err_underflow), 64'd1);
    bus.s_addr_valid = 3'b001;
    new_info();
    cycle();
    bus.rsp_done = 3'b001;
    new_info();
    cycle();
    bus.rsp_done = '0;
    grant_log.delete();
    for (int c = 0; c < 3; c++) begin new_info(); cycle(); end
    chk("cancel_grants", 64'(grant_log.size()), 64'd1);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      bus.s_addr_valid = 3'($urandom_range(0, 7));
      bus.addr_ready   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NS; i++)
        bus.rsp_done[i] = (m_cnt[i] > 0 && $urandom_range(0, 2) == 0) ||
                          ($urandom_range(0, 63) == 0);
      new_info();
      cycle();
    end

    // Reset mid-transfer: outputs clear without a clock edge.
    bus.rsp_done     = '0;
    bus.s_addr_valid = 3'b111;
    bus.addr_ready   = 1'b1;
    cycle();
    cycle();
    chk("pre_rst_valid", 64'(bus.addr_valid), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi_interconnect_crossbar_credit_arbit.md
AXI_INTERCONNECT_CROSSBAR_CREDIT_ARBIT -- requirements
Module: axi_interconnect_crossbar_credit_arbit

Interface
REQ-001 SHALL have parameter NUM_SLAVE, default 4: number of requesting slave ports, legal range 1..4.
REQ-002 SHALL have parameter WIDTH_ADDRINFO, default 64: width of one packed address-info word.
REQ-003 SHALL have parameter NUM_OUTSTANDING, default 4: per-port outstanding limit, legal range 1..16.
REQ-004 SHALL have parameter WIDTH_SALVE, default LOG2(NUM_SLAVE-1), minimum 1: width of the port index.
REQ-005 SHALL have parameter WIDTH_CNT, default LOG2(NUM_OUTSTANDING): width of each credit counter.
REQ-006 SHALL have parameter U_DLY, default 1: delay on sequential assignments.
REQ-007 SHALL have port clk_sys, input, 1: single system clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port s_addr_info, input, NUM_SLAVE*WIDTH_ADDRINFO: per-port address info, port i at slice i.
REQ-010 SHALL have port s_addr_valid, input, NUM_SLAVE: per-port request.
REQ-011 SHALL have port s_addr_ready, output, NUM_SLAVE: one-hot grant, combinational.
REQ-012 SHALL have port addr_info, output, WIDTH_ADDRINFO+WIDTH_SALVE: {info, granted index}, with the index in the LSBs.
REQ-013 SHALL have port addr_valid, output, 1: registered downstream valid.
REQ-014 SHALL have port addr_ready, input, 1: downstream ready.
REQ-015 SHALL have port rsp_done, input, NUM_SLAVE: one-cycle pulse per completed transaction of port i.
REQ-016 SHALL have port busy, output, 1: high while any credit counter is non-zero.
REQ-017 SHALL have port err_underflow, output, 1: sticky; set when rsp_done[i] arrives while cnt[i]==0.

Function
REQ-018 The output register SHALL load when load = ~addr_valid | addr_ready.
REQ-019 Eligibility SHALL be eligible[i] = s_addr_valid[i] & (cnt[i] < NUM_OUTSTANDING).
REQ-020 Arbitration SHALL be round-robin: search starts at last+1 and wraps modulo NUM_SLAVE; `last` updates only on a grant.
REQ-021 On load with any eligible port, the block SHALL raise s_addr_ready for exactly the winner, register addr_info and addr_valid=1 at the next edge, and set last to the winner.
REQ-022 On load with no eligible port, the block SHALL drive s_addr_ready=0 and register addr_valid=0.
REQ-023 While addr_valid=1 and addr_ready=0, addr_info/addr_valid SHALL hold and s_addr_ready SHALL be 0.
REQ-024 Latency SHALL be one cycle from grant to addr_valid, with throughput of one grant per cycle.
REQ-025 cnt[i] SHALL increment on grant to i and decrement on rsp_done[i]; both in the same cycle leaves it unchanged.
REQ-026 cnt[i] SHALL never exceed NUM_OUTSTANDING, and SHALL never decrement below 0 (that case sets err_underflow instead).
REQ-027 A port at its limit SHALL be skipped without blocking other ports.
REQ-028 A rsp_done in the same cycle a counter reaches its limit SHALL allow that port to become eligible the following cycle.
REQ-029 busy SHALL be a combinational OR of (cnt[i]!=0).

Reset
REQ-030 While rst_n=0: addr_valid=0, addr_info=0, all cnt=0, last=NUM_SLAVE-1 (port 0 wins first), err_underflow=0.
REQ-031 Reset asserted mid-transfer SHALL discard the pending output and all credits immediately, without waiting for a clock edge.

Configuration
REQ-032 Macro AXI_IC_CREDIT_ARBIT_STAT_EN SHALL control the statistics feature.
REQ-033 With AXI_IC_CREDIT_ARBIT_STAT_EN defined, the block SHALL add output stat_grant_cnt of 32*NUM_SLAVE bits.
REQ-034 stat_grant_cnt SHALL hold a per-port 32-bit grant counter that wraps at 2^32 and resets to 0.
REQ-035 Without AXI_IC_CREDIT_ARBIT_STAT_EN, the stat_grant_cnt port and counters SHALL be absent, with all other behaviour identical.

Verification (NUM_SLAVE=3, NUM_OUTSTANDING=2)
REQ-036 Reset release, then s_addr_valid=3'b111 with addr_ready=1 -> grants in the order 0,1,2,0,1,2; addr_info LSBs are 0,1,2; 6 grants end with cnt=2 for each port.
REQ-037 Port 1 alone with no rsp_done -> exactly 2 grants, then s_addr_ready stays 0 and busy=1; one rsp_done[1] pulse -> one further grant on the next load cycle.
REQ-038 s_addr_valid=3'b011 with port 0 at cnt=2 -> port 1 is granted every load cycle until it reaches its limit; port 0 is never granted.
REQ-039 addr_ready=0 for 5 cycles with addr_valid=1 -> addr_info is stable and s_addr_ready=0; addr_ready=1 -> the next grant occurs in the same cycle.
REQ-040 rsp_done[2] while cnt[2]=0 -> err_underflow=1 and stays set, cnt[2]=0; grant and rsp_done on port 0 in the same cycle -> cnt[0] unchanged.
REQ-041 Assert rst_n low while addr_valid=1 and counters are non-zero -> all outputs are at reset values immediately; with STAT_EN, stat_grant_cnt is 0.
